// File: rtl/uart_frame_check_if.sv
// Bus between the UART receiver datapath and the frame checker: frame/window
// controls and sampling inputs in, per-frame verdicts and error statistics out.
interface uart_frame_check_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int CNT_WIDTH      = 8
);
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic [3:0]                data_len;
  logic                      par_en;
  logic [1:0]                par_mode;
  logic                      sampled_bit;
  logic                      frame_start;
  logic                      par_chk_en;
  logic                      stp_chk_en;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic                      err_clr;
  logic                      par_err;
  logic                      stp_err;
  logic                      frame_done;
  logic                      err_sticky;
  logic [CNT_WIDTH-1:0]      par_err_cnt;
  logic [CNT_WIDTH-1:0]      stp_err_cnt;

  modport master (
    output P_DATA, data_len, par_en, par_mode, sampled_bit, frame_start,
           par_chk_en, stp_chk_en, edge_cnt, Prescale, err_clr,
    input  par_err, stp_err, frame_done, err_sticky, par_err_cnt, stp_err_cnt
  );

  modport slave (
    input  P_DATA, data_len, par_en, par_mode, sampled_bit, frame_start,
           par_chk_en, stp_chk_en, edge_cnt, Prescale, err_clr,
    output par_err, stp_err, frame_done, err_sticky, par_err_cnt, stp_err_cnt
  );
endinterface

// File: rtl/uart_frame_check.sv
// UART frame checker: evaluates parity and stop bit at the oversampling
// sample point, pulses frame_done and keeps saturating error statistics.
module uart_frame_check #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int SAMPLE_OFFSET  = 2,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                CLK,
  input  logic                RST,
  uart_frame_check_if.slave   bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_STP = 2'd1,
    DONE     = 2'd2
  } state_e;

  localparam logic [3:0] DW4 = 4'(DATA_WIDTH);

  state_e                    state_q, state_d;
  logic                      par_err_q, par_err_d;
  logic                      stp_err_q, stp_err_d;
  logic                      frame_done_q, frame_done_d;
  logic                      err_sticky_q, err_sticky_d;
  logic [CNT_WIDTH-1:0]      par_err_cnt_q, par_err_cnt_d;
  logic [CNT_WIDTH-1:0]      stp_err_cnt_q, stp_err_cnt_d;

  logic [3:0]                eff_len_s;
  logic [DATA_WIDTH-1:0]     data_masked_s;
  logic [PRESCALE_WIDTH-1:0] sp_s;
  logic                      strobe_s;
  logic                      exp_par_s;
  logic                      par_hit_s;
  logic                      stp_hit_s;
  logic [CNT_WIDTH-1:0]      par_cnt_base_s;
  logic [CNT_WIDTH-1:0]      stp_cnt_base_s;
  logic                      sticky_base_s;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic [1:0]            mode);
    case (mode)
      2'b00:   return ^d;
      2'b01:   return ~^d;
      2'b10:   return 1'b1;
      2'b11:   return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 inc);
    if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
      return cnt + CNT_WIDTH'(1);
    end else begin
      return cnt;
    end
  endfunction

  // Data masking, sample-point strobe and expected parity.
  always_comb begin
    if ((bus.data_len < 4'd5) || (bus.data_len > DW4)) begin
      eff_len_s = DW4;
    end else begin
      eff_len_s = bus.data_len;
    end
    data_masked_s = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      data_masked_s[i] = bus.P_DATA[i] & (4'(i) < eff_len_s);
    end
    sp_s      = (bus.Prescale >> 1) + PRESCALE_WIDTH'(SAMPLE_OFFSET);
    strobe_s  = (bus.edge_cnt == sp_s);
    exp_par_s = calc_parity(data_masked_s, bus.par_mode);
    // A stop strobe always takes precedence over a simultaneous parity window.
    stp_hit_s = strobe_s & bus.stp_chk_en;
    par_hit_s = strobe_s & bus.par_chk_en & bus.par_en & ~bus.stp_chk_en;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; frame_start restarts the frame from any state.
  always_comb begin
    state_d = state_q;
    if (bus.frame_start) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (stp_hit_s) begin
            state_d = DONE;
          end else if (par_hit_s) begin
            state_d = WAIT_STP;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT_STP: begin
          if (stp_hit_s) begin
            state_d = DONE;
          end else begin
            state_d = WAIT_STP;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: flag evaluation, done pulse and error statistics.
  always_comb begin
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
    if (bus.frame_start) begin
      par_err_d = 1'b0;
      stp_err_d = 1'b0;
    end else if ((state_q == IDLE) && stp_hit_s) begin
      stp_err_d = ~bus.sampled_bit;
      par_err_d = bus.par_en;
    end else if ((state_q == IDLE) && par_hit_s) begin
      par_err_d = exp_par_s ^ bus.sampled_bit;
    end else if ((state_q == WAIT_STP) && stp_hit_s) begin
      stp_err_d = ~bus.sampled_bit;
    end else begin
      par_err_d = par_err_q;
      stp_err_d = stp_err_q;
    end

    frame_done_d = (state_d == DONE);

    // A clear coinciding with DONE restarts from zero, then counts this frame.
    par_cnt_base_s = bus.err_clr ? {CNT_WIDTH{1'b0}} : par_err_cnt_q;
    stp_cnt_base_s = bus.err_clr ? {CNT_WIDTH{1'b0}} : stp_err_cnt_q;
    sticky_base_s  = bus.err_clr ? 1'b0 : err_sticky_q;
    if (state_q == DONE) begin
      par_err_cnt_d = sat_inc(par_cnt_base_s, par_err_q);
      stp_err_cnt_d = sat_inc(stp_cnt_base_s, stp_err_q);
      err_sticky_d  = sticky_base_s | par_err_q | stp_err_q;
    end else begin
      par_err_cnt_d = par_cnt_base_s;
      stp_err_cnt_d = stp_cnt_base_s;
      err_sticky_d  = sticky_base_s;
    end
  end

  // Output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      err_sticky_q  <= 1'b0;
      par_err_cnt_q <= {CNT_WIDTH{1'b0}};
      stp_err_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      frame_done_q  <= frame_done_d;
      err_sticky_q  <= err_sticky_d;
      par_err_cnt_q <= par_err_cnt_d;
      stp_err_cnt_q <= stp_err_cnt_d;
    end
  end

  assign bus.par_err     = par_err_q;
  assign bus.stp_err     = stp_err_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.par_err_cnt = par_err_cnt_q;
  assign bus.stp_err_cnt = stp_err_cnt_q;
endmodule

// File: tb/tb_uart_frame_check.sv
// Directed bench for uart_frame_check: frame-level model of the expected
// verdicts and statistics, checked against the DUT on every falling edge.
module tb_uart_frame_check;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_check_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6), .CNT_WIDTH(8)) bus ();

  uart_frame_check #(
    .DATA_WIDTH(8), .PRESCALE_WIDTH(6), .SAMPLE_OFFSET(2), .CNT_WIDTH(8)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  bit cmp_en = 1'b0;

  bit exp_par, exp_stp, exp_done, exp_sticky;
  int exp_pcnt, exp_scnt;

  task automatic check(input string name, input logic [31:0] act, input int expv);
    n_vec++;
    if (act !== 32'(expv)) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("par_err",     32'(bus.par_err),     int'(exp_par));
      check("stp_err",     32'(bus.stp_err),     int'(exp_stp));
      check("frame_done",  32'(bus.frame_done),  int'(exp_done));
      check("err_sticky",  32'(bus.err_sticky),  int'(exp_sticky));
      check("par_err_cnt", 32'(bus.par_err_cnt), exp_pcnt);
      check("stp_err_cnt", 32'(bus.stp_err_cnt), exp_scnt);
    end
  end

  // One clock; statistics follow from the completed frame and err_clr.
  task automatic tick();
    bit clr = bus.err_clr;
    bit r   = rst;
    @(posedge clk);
    #1;
    if (r) begin
      exp_par = 0; exp_stp = 0; exp_done = 0; exp_sticky = 0;
      exp_pcnt = 0; exp_scnt = 0;
    end else if (exp_done) begin
      if (clr) begin
        exp_pcnt = 0; exp_scnt = 0; exp_sticky = 0;
      end
      if (exp_par && exp_pcnt < 255) exp_pcnt++;
      if (exp_stp && exp_scnt < 255) exp_scnt++;
      exp_sticky = exp_sticky | exp_par | exp_stp;
      exp_done = 0;
    end else if (clr) begin
      exp_pcnt = 0; exp_scnt = 0; exp_sticky = 0;
    end
  endtask

  function automatic int sample_point();
    return ((int'(bus.Prescale) >> 1) + 2) % 64;
  endfunction

  // One frame: optional parity window (repeated with inverted data to show
  // only the first evaluation counts), then the stop window.
  task automatic frame(input logic [7:0] pd, input logic [3:0] len, input logic [1:0] mode,
                       input bit pen, input bit do_par, input bit pbit, input bit sbit,
                       input bit both, input bit clr_done);
    int  eff   = (len < 5 || len > 8) ? 8 : int'(len);
    int  ones  = $countones(32'(pd) & ((1 << eff) - 1));
    bit  even  = ones[0];
    bit  expp  = (mode == 2'd0) ? even : (mode == 2'd1) ? !even : (mode == 2'd2);
    bit  want;
    int  sp    = sample_point();
    want = !pen ? 1'b0 : (do_par && !both) ? (expp ^ pbit) : 1'b1;
    bus.P_DATA = pd; bus.data_len = len; bus.par_mode = mode; bus.par_en = pen;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    exp_par = 0; exp_stp = 0;
    if (do_par && !both) begin
      for (int w = 0; w < 2; w++) begin
        for (int e = sp - 2; e <= sp + 1; e++) begin
          bus.par_chk_en  = 1'b1;
          bus.edge_cnt    = 6'(e);
          bus.sampled_bit = (e == sp && w == 0) ? pbit : !pbit;
          tick();
          if (e == sp && w == 0 && pen) exp_par = expp ^ pbit;
        end
      end
      bus.par_chk_en = 1'b0;
    end
    for (int e = sp - 2; e <= sp + 1; e++) begin
      bus.stp_chk_en  = 1'b1;
      bus.par_chk_en  = both;
      bus.err_clr     = clr_done && (e == sp + 1);
      bus.edge_cnt    = 6'(e);
      bus.sampled_bit = (e == sp) ? sbit : !sbit;
      tick();
      if (e == sp) begin
        exp_stp = !sbit; exp_par = want; exp_done = 1;
      end
    end
    bus.stp_chk_en = 1'b0; bus.par_chk_en = 1'b0; bus.err_clr = 1'b0;
  endtask

  initial begin
    bus.P_DATA = 8'h00; bus.data_len = 4'd8; bus.par_en = 1'b0; bus.par_mode = 2'd0;
    bus.sampled_bit = 1'b1; bus.frame_start = 1'b0; bus.par_chk_en = 1'b0;
    bus.stp_chk_en = 1'b0; bus.edge_cnt = 6'd0; bus.Prescale = 6'd8; bus.err_clr = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Even parity, 0x03, parity 0 at edge 6, stop 1: clean frame.
    frame(8'h03, 4'd8, 2'd0, 1, 1, 0, 1, 0, 0);
    check("pin_clean_par", 32'(bus.par_err), 0);
    check("pin_clean_pcnt", 32'(bus.par_err_cnt), 0);
    // Odd parity, 0x01, parity bit 1 is wrong.
    frame(8'h01, 4'd8, 2'd1, 1, 1, 1, 1, 0, 0);
    check("pin_odd_par", 32'(bus.par_err), 1);
    check("pin_odd_pcnt", 32'(bus.par_err_cnt), 1);
    check("pin_odd_sticky", 32'(bus.err_sticky), 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("pin_clr_pcnt", 32'(bus.par_err_cnt), 0);
    check("pin_clr_sticky", 32'(bus.err_sticky), 0);
    // Five data bits: 0xE1 masks to 0x01, even parity 1 is right; stop 0 bad.
    frame(8'hE1, 4'd5, 2'd0, 1, 1, 1, 0, 0, 0);
    check("pin_mask_par", 32'(bus.par_err), 0);
    check("pin_mask_scnt", 32'(bus.stp_err_cnt), 1);
    frame(8'h00, 4'd8, 2'd2, 1, 1, 0, 1, 0, 0);   // mark, sample 0 -> error
    frame(8'h00, 4'd8, 2'd3, 1, 1, 0, 1, 0, 0);   // space, sample 0 -> ok
    frame(8'h80, 4'd4, 2'd0, 1, 1, 0, 1, 0, 0);   // len 4 acts as 8 -> error
    frame(8'h80, 4'd7, 2'd0, 1, 1, 0, 1, 0, 0);   // bit 7 masked -> ok
    frame(8'hFF, 4'd8, 2'd0, 0, 1, 1, 1, 0, 0);   // parity disabled
    frame(8'h03, 4'd8, 2'd0, 1, 0, 0, 1, 1, 0);   // both windows on one strobe
    bus.Prescale = 6'd12;
    frame(8'h03, 4'd8, 2'd0, 1, 1, 1, 1, 0, 0);   // sample point 8
    bus.Prescale = 6'd8;
    // Parity window missed entirely.
    frame(8'h03, 4'd8, 2'd0, 1, 0, 0, 1, 0, 0);
    check("pin_missed_par", 32'(bus.par_err), 1);

    // frame_start beats a coincident stop strobe.
    bus.frame_start = 1'b1; bus.stp_chk_en = 1'b1; bus.edge_cnt = 6'd6; bus.sampled_bit = 1'b0;
    tick();
    exp_par = 0; exp_stp = 0;
    bus.frame_start = 1'b0; bus.stp_chk_en = 1'b0;
    tick();
    check("pin_override_stp", 32'(bus.stp_err), 0);
    check("pin_override_done", 32'(bus.frame_done), 0);

    // Saturation of the parity counter.
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    for (int k = 0; k < 255; k++) frame(8'h01, 4'd8, 2'd1, 1, 1, 1, 1, 0, 0);
    check("pin_sat_full", 32'(bus.par_err_cnt), 255);
    frame(8'h01, 4'd8, 2'd1, 1, 1, 1, 1, 0, 0);
    check("pin_sat_hold", 32'(bus.par_err_cnt), 255);
    frame(8'h01, 4'd8, 2'd1, 1, 1, 1, 1, 0, 1);
    check("pin_clr_at_done", 32'(bus.par_err_cnt), 1);

    // Reset while waiting for the stop bit.
    bus.P_DATA = 8'h01; bus.par_mode = 2'd1; bus.par_en = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    exp_par = 0; exp_stp = 0;
    bus.par_chk_en = 1'b1; bus.edge_cnt = 6'd6; bus.sampled_bit = 1'b1;
    tick();
    exp_par = 1;
    bus.par_chk_en = 1'b0; bus.edge_cnt = 6'd7;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("pin_rst_par", 32'(bus.par_err), 0);
    check("pin_rst_pcnt", 32'(bus.par_err_cnt), 0);
    check("pin_rst_sticky", 32'(bus.err_sticky), 0);
    frame(8'h03, 4'd8, 2'd0, 1, 1, 0, 1, 0, 0);
    check("pin_after_rst_par", 32'(bus.par_err), 0);
    check("pin_after_rst_stp", 32'(bus.stp_err), 0);
    tick();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
